// File: rtl/pool_window_sequencer.sv
`timescale 1ns/1ps
// ============================================================================
// pool_window_sequencer
//
// Purpose
//   Control stage in front of a 2x2 pixel-averaging unit. It walks an
//   IMG_W x IMG_H frame buffer in non-overlapping 2x2 windows in raster
//   order. For each window it:
//     - reads the four pixels (TL, TR, BL, BR),
//     - presents them on in1..in4 with a pool_en strobe,
//     - captures the returned average,
//     - writes the average to a (IMG_W/2) x (IMG_H/2) pooled buffer.
//   A start/busy/done handshake frames one full pass.
//
// Ports
//   clk        system clock; all logic runs on the rising edge
//   reset      asynchronous, active-high reset; aborts a pass immediately
//   start      begins one pooling pass (sampled only while idle)
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse after the last window is written
//   rd_en      frame-buffer read enable
//   rd_addr    frame-buffer address, row*IMG_W+col
//   rd_data    frame-buffer data, valid one cycle after rd_en
//   pool_en    window-valid strobe to the averaging unit
//   in1..in4   top-left, top-right, bottom-left, bottom-right pixels
//   avg_in     average returned by the averaging unit
//   pool_done  averaging-unit completion flag
//   wr_en      pooled-buffer write strobe
//   wr_addr    pooled-buffer address, (row/2)*(IMG_W/2)+col/2
//   wr_data    average captured while pool_en was high
//
// Build option
//   POOL_ACK_EN
//     defined:   the POOL state holds, with pool_en high, until pool_done
//                is seen.
//     undefined: POOL lasts exactly one cycle and pool_done is ignored.
//
// Timing
//   Without POOL_ACK_EN every window takes 7 cycles:
//   RD0 RD1 RD2 RD3 CAP POOL WRITE.
// ============================================================================
module pool_window_sequencer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 8,
    parameter int RD_AW = 10,
    parameter int WR_AW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [RD_AW-1:0] rd_addr,
    input  logic [PIX_W-1:0] rd_data,
    output logic             pool_en,
    output logic [PIX_W-1:0] in1,
    output logic [PIX_W-1:0] in2,
    output logic [PIX_W-1:0] in3,
    output logic [PIX_W-1:0] in4,
    input  logic [PIX_W-1:0] avg_in,
    input  logic             pool_done,
    output logic             wr_en,
    output logic [WR_AW-1:0] wr_addr,
    output logic [PIX_W-1:0] wr_data
);

    // The counters must be able to hold IMG_H / IMG_W themselves, because
    // the next-column value is formed before it is compared.
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int COL_W = $clog2(IMG_W + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_CAP,
        S_POOL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q;

    // Window origin (pixel coordinates of the top-left pixel)
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_d;

    // Running frame address of the window origin; avoids a row*IMG_W multiply
    logic [RD_AW-1:0] base_q;
    logic [RD_AW-1:0] base_d;

    // Running pooled-buffer index; equals (row/2)*(IMG_W/2)+col/2
    logic [WR_AW-1:0] wr_idx_q;

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic             rd_en_q;
    logic [RD_AW-1:0] rd_addr_q;
    logic             pool_en_q;
    logic [PIX_W-1:0] in1_q;
    logic [PIX_W-1:0] in2_q;
    logic [PIX_W-1:0] in3_q;
    logic [PIX_W-1:0] in4_q;
    logic             wr_en_q;
    logic [WR_AW-1:0] wr_addr_q;
    logic [PIX_W-1:0] wr_data_q;

    logic row_end;
    logic last_win;
    logic pool_fire;

    // ------------------------------------------------------------------
    // POOL exit condition
    // ------------------------------------------------------------------
`ifdef POOL_ACK_EN
    assign pool_fire = pool_done;
`else
    logic pool_done_unused;
    assign pool_done_unused = pool_done;
    assign pool_fire        = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-window arithmetic
    // ------------------------------------------------------------------
    assign row_end  = (col_q == COL_W'(IMG_W - 2));
    assign last_win = row_end && (row_q == ROW_W'(IMG_H - 2));

    always_comb begin
        row_d  = row_q;
        col_d  = col_q + COL_W'(2);
        base_d = base_q + RD_AW'(2);
        if (row_end) begin
            // Wrap to column 0 two rows down.
            // From (r, IMG_W-2), the origin address grows by IMG_W+2.
            row_d  = row_q + ROW_W'(2);
            col_d  = '0;
            base_d = base_q + RD_AW'(IMG_W + 2);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            base_q    <= '0;
            wr_idx_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            pool_en_q <= 1'b0;
            in1_q     <= '0;
            in2_q     <= '0;
            in3_q     <= '0;
            in4_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RD0;
                        busy_q    <= 1'b1;
                        row_q     <= '0;
                        col_q     <= '0;
                        base_q    <= '0;
                        wr_idx_q  <= '0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end

                // Each RDn state issues the next address.
                // It also latches the pixel requested one cycle earlier.
                S_RD0: begin
                    state_q   <= S_RD1;
                    rd_addr_q <= base_q + RD_AW'(1);
                end

                S_RD1: begin
                    state_q   <= S_RD2;
                    in1_q     <= rd_data;
                    rd_addr_q <= base_q + RD_AW'(IMG_W);
                end

                S_RD2: begin
                    state_q   <= S_RD3;
                    in2_q     <= rd_data;
                    rd_addr_q <= base_q + RD_AW'(IMG_W + 1);
                end

                S_RD3: begin
                    state_q <= S_CAP;
                    in3_q   <= rd_data;
                    rd_en_q <= 1'b0;
                end

                S_CAP: begin
                    state_q   <= S_POOL;
                    in4_q     <= rd_data;
                    pool_en_q <= 1'b1;
                    wr_addr_q <= wr_idx_q;
                end

                S_POOL: begin
                    if (pool_fire) begin
                        state_q   <= S_WRITE;
                        wr_data_q <= avg_in;
                        pool_en_q <= 1'b0;
                        wr_en_q   <= 1'b1;
                    end
                end

                S_WRITE: begin
                    wr_en_q  <= 1'b0;
                    wr_idx_q <= wr_idx_q + WR_AW'(1);
                    if (last_win) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= S_RD0;
                        row_q     <= row_d;
                        col_q     <= col_d;
                        base_q    <= base_d;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= base_d;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    rd_en_q   <= 1'b0;
                    pool_en_q <= 1'b0;
                    wr_en_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign pool_en = pool_en_q;
    assign in1     = in1_q;
    assign in2     = in2_q;
    assign in3     = in3_q;
    assign in4     = in4_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: doc/pool_window_sequencer.md
Name: pool_window_sequencer

Overview:
- Upstream control stage for the 2x2 pixel-averaging unit in the digit-recognition front end.
- Scans a PIX_W-bit frame buffer of IMG_W x IMG_H pixels (28x28 drawn digit) in non-overlapping 2x2 windows.
- Presents each window's four pixels with a pool_en strobe, captures the averaged result, and writes it to a pooled buffer of (IMG_W/2) x (IMG_H/2) in raster order.
- Start/busy/done handshake toward the top-level controller.

Parameters:
IMG_W, 28, frame width in pixels; must be even
IMG_H, 28, frame height in pixels; must be even
PIX_W, 8, pixel and average width in bits
RD_AW, 10, frame-buffer address width; must be >= clog2(IMG_W*IMG_H)
WR_AW, 8, pooled-buffer address width; must be >= clog2(IMG_W*IMG_H/4)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin one full-frame pooling pass; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last window is written
rd_en  out  1  frame-buffer read enable
rd_addr  out  RD_AW  frame-buffer address, row*IMG_W+col
rd_data  in  PIX_W  frame-buffer data; valid exactly 1 cycle after rd_en
pool_en  out  1  window valid strobe to the averaging unit
in1  out  PIX_W  top-left pixel
in2  out  PIX_W  top-right pixel
in3  out  PIX_W  bottom-left pixel
in4  out  PIX_W  bottom-right pixel
avg_in  in  PIX_W  average returned by the averaging unit (combinational from in1..in4)
pool_done  in  1  averaging-unit completion flag (used only with POOL_ACK_EN)
wr_en  out  1  pooled-buffer write strobe
wr_addr  out  WR_AW  pooled-buffer address, (row/2)*(IMG_W/2)+col/2
wr_data  out  PIX_W  value written to the pooled buffer; equals avg_in captured in POOL

Behaviour:
- Reset: state=IDLE.
  - busy, done, rd_en, pool_en and wr_en are 0.
  - rd_addr, wr_addr, wr_data and in1..in4 are 0.
  - Window row/col counters are 0.
  - Reset asserted mid-pass aborts immediately. No further writes occur, and a new start is needed.
- States: IDLE, RD0, RD1, RD2, RD3, CAP, POOL, WRITE, DONE.
- IDLE: start=1 moves to RD0 and sets busy. Start in any other state is ignored.
- Read sequence (window origin r,c):
  - RD0: rd_en=1, addr=TL (r,c).
  - RD1: addr=TR (r,c+1); latch rd_data into in1.
  - RD2: addr=BL (r+1,c); latch into in2.
  - RD3: addr=BR (r+1,c+1); latch into in3.
  - CAP: rd_en=0; latch into in4.
- POOL:
  - pool_en=1, with in1..in4 stable.
  - avg_in is registered into wr_data at the end of the cycle.
- WRITE: wr_en=1 for exactly one cycle.
- Window advance after WRITE:
  - c+=2.
  - If c reaches IMG_W, then c=0 and r+=2.
  - If this was the last window (r=IMG_H-2, c=IMG_W-2), go to DONE. Otherwise go to RD0.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- Latency:
  - 7 cycles per window without POOL_ACK_EN.
  - Full 28x28 pass: 196 windows, 196*7=1372 busy cycles, done on the cycle after the final WRITE.
- Strobes: pool_en and wr_en are never high simultaneously. rd_en is high only in RD0..RD3.
- in1..in4 hold their last values between windows and after done.
- Widths:
  - Address arithmetic is unsigned with no wrap.
  - The last rd_addr is IMG_W*IMG_H-1.
  - The last wr_addr is IMG_W*IMG_H/4-1.

Optional Feature:
- POOL_ACK_EN defined:
  - POOL holds, with pool_en=1, until pool_done=1. avg_in is captured on that cycle, then the FSM moves to WRITE.
  - No timeout. reset is the only exit from a stuck POOL.
- POOL_ACK_EN undefined:
  - pool_done is ignored.
  - POOL lasts exactly one cycle.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> all outputs 0, busy=0. A start pulse during reset produces no activity.
- Ramp frame: pixel(r,c)=(r*28+c)&0xFF, with a model averager returning (in1+in2+in3+in4)>>2 -> 196 writes.
  - wr_addr runs 0..195 in order.
  - Window 0 shows in1..in4=0,1,28,29 and writes 14.
  - done arrives at cycle 1373 after start.
- Saturated and zero windows: TL window all 255 -> wr_data 255. Window at (2,4) all 0 -> wr_data 0 at wr_addr 16.
- Start while busy: pulse start at cycles 10 and 500 -> exactly 196 writes and a single done pulse.
- Reset mid-pass: assert reset during window 50 POOL -> wr_en goes 0 at once, no write to wr_addr 50. A fresh start restarts at wr_addr 0.
- POOL_ACK_EN build: delay pool_done by 3 cycles per window -> POOL lasts 4 cycles, each window takes 10 cycles, all 196 values are still correct.
